// File: rtl/screen_rx_module.sv
// screen_rx_module: 8N1 UART receiver with a valid/ready byte output, framing and overrun flags.
// Define SCREEN_RX_PARITY_EN to expect an even-parity bit after the data bits.
module screen_rx_module #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);
  localparam int DW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] HALF = DW'(BAUD_DIV / 2 - 1);
  localparam logic [DW-1:0] FULL = DW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`ifdef SCREEN_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic pbad_q;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t               state_q;
  logic [1:0]           sync_q;
  logic [DW-1:0]        div_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 valid_q, ferr_q, ovr_q, perr_q;
  logic                 rx_s, tick;
  assign rx_s       = sync_q[1];
  assign tick       = div_q == FULL;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
`ifdef SCREEN_RX_PARITY_EN
      pbad_q  <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], rx_in};
      div_q  <= div_q + 1'b1;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      if (valid_q && out_ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: if (div_q == HALF) begin
          div_q   <= '0;
          bit_q   <= '0;
          state_q <= rx_s ? IDLE : DATA;
        end
        DATA: if (tick) begin
          div_q   <= '0;
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          bit_q   <= bit_q + 1'b1;
          if (bit_q == LAST) state_q <= AFTER_DATA;
        end
`ifdef SCREEN_RX_PARITY_EN
        PARITY: if (tick) begin
          div_q   <= '0;
          pbad_q  <= ^shift_q ^ rx_s;
          state_q <= STOP;
        end
`endif
        STOP: if (tick) begin
          div_q <= '0;
`ifdef SCREEN_RX_PARITY_EN
          perr_q <= pbad_q;
`endif
          // A waiting byte may only be replaced if it is being accepted this same cycle
          if (rx_s) begin
            state_q <= IDLE;
            if (!valid_q || out_ready) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else ovr_q <= 1'b1;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_screen_rx_module.sv
// tb_screen_rx_module: directed vector bench for the UART receiver at BAUD_DIV=16.
module tb_screen_rx_module;
  localparam int D = 16;
`ifdef SCREEN_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 2 + D / 2 + (9 + PAR) * D;

  logic       clk, reset, rx_in, out_ready;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun, parity_err;

  screen_rx_module #(.BAUD_DIV(D), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int vcnt, hs_cnt, ferr_cnt, ovr_cnt, perr_cnt;
  int rise_cyc, ferr_cyc, ovr_cyc, perr_cyc, start_cyc;
  logic [7:0] hs_data, prev_data;
  logic saw_c3, held_bad, prev_valid, prev_ready;

  task automatic clr();
    vcnt = 0; hs_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0;
    rise_cyc = -1; ferr_cyc = -1; ovr_cyc = -1; perr_cyc = -1;
    hs_data = 8'h00; saw_c3 = 1'b0; held_bad = 1'b0;
  endtask

  // Outputs sampled mid-cycle, after the negedge drivers have settled
  always @(negedge clk) begin
    #1;
    if (out_valid) vcnt++;
    if (out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    if (out_valid && out_ready) begin hs_cnt++; hs_data = out_data; end
    if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
    if (overrun) begin ovr_cnt++; ovr_cyc = cyc; end
    if (parity_err) begin perr_cnt++; perr_cyc = cyc; end
    if (out_valid && out_data == 8'hC3) saw_c3 = 1'b1;
    if (prev_valid && !prev_ready && (!out_valid || out_data !== prev_data)) held_bad = 1'b1;
    prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rx_in at the stop-bit level so a low stop bit can be stretched by the caller
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    logic [10:0] bits;
    bits = (PAR == 1) ? {stop_b, par_b, d, 1'b0} : {1'b1, stop_b, d, 1'b0};
    start_cyc = cyc + 1;
    for (int i = 0; i < 10 + PAR; i++) begin
      rx_in = bits[i];
      idle(D);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_v;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [9:0] part;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h33, 1'b0, 1'b0, 1'b1};
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = 8'h00;
    clr();
    reset = 1'b1; rx_in = 1'b1; out_ready = 1'b1;
    idle(4);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset parity_err", parity_err, 0);
    reset = 1'b0;
    idle(10);

    for (int i = 0; i < 7; i++) begin
      clr();
      send_frame(vecs[i].d, vecs[i].stop, ^vecs[i].d);
      rx_in = 1'b1;
      idle(20);
      chk($sformatf("vec%0d valid cycles", i), vcnt, {31'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d frame_err", i), ferr_cnt, {31'd0, vecs[i].exp_ferr});
      chk($sformatf("vec%0d overrun", i), ovr_cnt, 0);
      chk($sformatf("vec%0d parity_err", i), perr_cnt, 0);
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d data", i), hs_data, vecs[i].d);
        chk($sformatf("vec%0d latency", i), rise_cyc - start_cyc, LAT);
      end else chk($sformatf("vec%0d ferr latency", i), ferr_cyc - start_cyc, LAT);
    end

    // Held byte with a stalled consumer, second frame overruns
    clr();
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle(20);
    chk("ovr valid held", out_valid, 1);
    chk("ovr data held", out_data, 8'h3C);
    chk("ovr pulse count", ovr_cnt, 1);
    chk("ovr pulse time", ovr_cyc - start_cyc, LAT);
    chk("ovr no handshake", hs_cnt, 0);
    out_ready = 1'b1;
    idle(5);
    chk("ovr accepted count", hs_cnt, 1);
    chk("ovr accepted data", hs_data, 8'h3C);
    chk("ovr valid cleared", out_valid, 0);
    chk("ovr C3 never seen", saw_c3, 0);
    chk("ovr data stable", held_bad, 0);

    // Bad stop bit followed by a break
    clr();
    send_frame(8'h55, 1'b0, ^8'h55);
    idle(40);
    rx_in = 1'b1;
    idle(220);
    chk("break frame_err count", ferr_cnt, 1);
    chk("break frame_err time", ferr_cyc - start_cyc, LAT);
    chk("break no valid", vcnt, 0);
    clr();
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(20);
    chk("after break data", hs_data, 8'h12);
    chk("after break count", hs_cnt, 1);
    chk("after break ferr", ferr_cnt, 0);

    // Short low glitch on the idle line
    clr();
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    idle(220);
    chk("glitch no valid", vcnt, 0);
    chk("glitch no ferr", ferr_cnt, 0);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(20);
    chk("after glitch data", hs_data, 8'hFF);
    chk("after glitch latency", rise_cyc - start_cyc, LAT);

    // Reset in the middle of the 4th data bit
    clr();
    part = {1'b1, 8'h0F, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx_in = part[i];
      idle(D);
    end
    rx_in = part[4];
    idle(D / 2);
    reset = 1'b1;
    idle(2);
    chk("midreset out_data", out_data, 0);
    chk("midreset out_valid", out_valid, 0);
    reset = 1'b0;
    rx_in = 1'b1;
    idle(250);
    chk("midreset no valid", vcnt, 0);
    chk("midreset no ferr", ferr_cnt, 0);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(20);
    chk("after reset data", hs_data, 8'h81);
    chk("after reset count", hs_cnt, 1);

`ifdef SCREEN_RX_PARITY_EN
    clr();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    chk("parity ok data", hs_data, 8'h07);
    chk("parity ok no err", perr_cnt, 0);
    clr();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    chk("parity bad data", hs_data, 8'h07);
    chk("parity bad pulse", perr_cnt, 1);
    chk("parity bad coincident", perr_cyc - rise_cyc, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
